// File: rtl/mem_port_arbiter.sv
// Per-port request front-end for the multiport RAM: holds one request per port,
// arbitrates same-address hazards round-robin and drives registered RAM buses.
module mem_port_arbiter #(
  parameter int PORT_COUNT = 2,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 12,
  parameter int STALL_W    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [PORT_COUNT-1:0]        req_valid,
  output logic [PORT_COUNT-1:0]        req_ready,
  input  logic [PORT_COUNT-1:0]        req_write,
  input  logic [ADDR_W*PORT_COUNT-1:0] req_addr,
  input  logic [DATA_W*PORT_COUNT-1:0] req_wdata,
  output logic [PORT_COUNT-1:0]        resp_valid,
  output logic [DATA_W*PORT_COUNT-1:0] resp_rdata,
  output logic [ADDR_W*PORT_COUNT-1:0] ram_address,
  output logic [DATA_W*PORT_COUNT-1:0] ram_datain,
  output logic [PORT_COUNT-1:0]        ram_mem_write,
  input  logic [DATA_W*PORT_COUNT-1:0] ram_dataout,
  output logic [STALL_W-1:0]           stall_count
);

  localparam int PTR_W = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;

  typedef enum logic [1:0] {IDLE, PEND, ISSUED, RESP} state_t;

  state_t              state      [PORT_COUNT];
  state_t              next_state [PORT_COUNT];
  logic                hold_write [PORT_COUNT];
  logic [ADDR_W-1:0]   hold_addr  [PORT_COUNT];
  logic [DATA_W-1:0]   hold_wdata [PORT_COUNT];
  logic [PTR_W-1:0]    rr_ptr;
  logic [PORT_COUNT-1:0] accept;
  logic [PORT_COUNT-1:0] grant;
  logic [PORT_COUNT-1:0] blocked;
  logic                first_found;
  logic [PTR_W-1:0]    first_blk;
  logic                hit;
  int                  nblk;
  int                  rank [PORT_COUNT];

  function automatic logic [STALL_W-1:0] sat_add(input logic [STALL_W-1:0] a,
                                                 input logic [STALL_W-1:0] b);
    logic [STALL_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[STALL_W] ? '1 : sum[STALL_W-1:0];
  endfunction

  always_comb begin
    for (int p = 0; p < PORT_COUNT; p++) begin
      req_ready[p]  = (state[p] == IDLE) || (state[p] == RESP);
      resp_valid[p] = (state[p] == RESP);
    end
  end

  assign accept     = req_valid & req_ready;
  assign resp_rdata = ram_dataout;

  // Visit pending ports in priority order; only already-granted ports can block.
  always_comb begin
    grant       = '0;
    blocked     = '0;
    nblk        = 0;
    first_found = 1'b0;
    first_blk   = rr_ptr;
    hit         = 1'b0;
    for (int p = 0; p < PORT_COUNT; p++)
      rank[p] = (p + PORT_COUNT - int'(rr_ptr)) % PORT_COUNT;
    for (int k = 0; k < PORT_COUNT; k++) begin
      for (int p = 0; p < PORT_COUNT; p++) begin
        if (rank[p] == k && state[p] == PEND) begin
          hit = 1'b0;
          for (int q = 0; q < PORT_COUNT; q++)
            if (grant[q] && rank[q] < k && hold_addr[q] == hold_addr[p] &&
                (hold_write[q] || hold_write[p]))
              hit = 1'b1;
          if (hit) begin
            blocked[p] = 1'b1;
            nblk       = nblk + 1;
            if (!first_found) begin
              first_found = 1'b1;
              first_blk   = PTR_W'(p);
            end
          end else begin
            grant[p] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < PORT_COUNT; p++) begin
      next_state[p] = state[p];
      case (state[p])
        IDLE:    if (accept[p]) next_state[p] = PEND;
        PEND:    if (grant[p])  next_state[p] = ISSUED;
        ISSUED:  next_state[p] = RESP;
        RESP:    next_state[p] = accept[p] ? PEND : IDLE;
        default: next_state[p] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr        <= '0;
      stall_count   <= '0;
      ram_address   <= '0;
      ram_datain    <= '0;
      ram_mem_write <= '0;
      for (int p = 0; p < PORT_COUNT; p++) begin
        state[p]      <= IDLE;
        hold_write[p] <= 1'b0;
        hold_addr[p]  <= '0;
        hold_wdata[p] <= '0;
      end
    end else begin
      for (int p = 0; p < PORT_COUNT; p++) begin
        state[p] <= next_state[p];
        if (accept[p]) begin
          hold_write[p] <= req_write[p];
          hold_addr[p]  <= req_addr[(p+1)*ADDR_W-1 -: ADDR_W];
          hold_wdata[p] <= req_wdata[(p+1)*DATA_W-1 -: DATA_W];
        end
        // The write strobe lives for the ISSUED cycle only; address/data hold.
        ram_mem_write[p] <= grant[p] & hold_write[p];
        if (grant[p]) begin
          ram_address[(p+1)*ADDR_W-1 -: ADDR_W] <= hold_addr[p];
          ram_datain[(p+1)*DATA_W-1 -: DATA_W]  <= hold_wdata[p];
        end
      end
      if (|blocked) begin
        rr_ptr      <= first_blk;
        stall_count <= sat_add(stall_count, STALL_W'(nblk));
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: behavioural RAM plus a transaction-level
// reference model (request records, issue timestamps, reference memory).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, req_write;
  logic [23:0] req_addr, req_wdata;
  logic [1:0]  resp_valid;
  logic [23:0] resp_rdata, ram_address, ram_datain, ram_dataout;
  logic [1:0]  ram_mem_write;
  logic [15:0] stall_count;
  logic        mem_clear;

  int tests = 0;
  int failures = 0;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .ram_address(ram_address),
    .ram_datain(ram_datain), .ram_mem_write(ram_mem_write), .ram_dataout(ram_dataout),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: writes land before reads at the same edge.
  logic [11:0] mem [4096];

  function automatic logic [11:0] ram_read(input int p);
    logic [11:0] a;
    logic [11:0] v;
    a = ram_address[p*12 +: 12];
    v = mem[a];
    for (int q = 0; q < 2; q++)
      if (ram_mem_write[q] && ram_address[q*12 +: 12] == a) v = ram_datain[q*12 +: 12];
    return v;
  endfunction

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        ram_dataout[p*12 +: 12] <= ram_read(p);
        if (ram_mem_write[p]) mem[ram_address[p*12 +: 12]] <= ram_datain[p*12 +: 12];
      end
    end
  end

  // Reference model state
  int          cyc = 0;
  bit          waiting [2];
  int          issued_at [2];
  bit          h_w [2];
  logic [11:0] h_a [2];
  logic [11:0] h_d [2];
  logic [11:0] exp_d [2];
  int          rr = 0;
  int          stall = 0;
  logic [11:0] ref_mem [4096];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      waiting[p] = 0;
      issued_at[p] = -10;
    end
    rr = 0;
    stall = 0;
  endtask

  // One clock cycle: drive at negedge, check outputs, advance model at posedge.
  task automatic step(input logic rst_in, input logic [1:0] v, input logic [1:0] w,
                      input logic [11:0] a0, input logic [11:0] a1,
                      input logic [11:0] d0, input logic [11:0] d1);
    logic [1:0] er, ev, em, acc;
    int granted [$];
    int first, nb;
    bit blk;
    reset = rst_in;
    req_valid = v;
    req_write = w;
    req_addr = {a1, a0};
    req_wdata = {d1, d0};
    #1;
    for (int p = 0; p < 2; p++) begin
      er[p] = !waiting[p] && (cyc != issued_at[p]);
      ev[p] = (cyc == issued_at[p] + 1);
      em[p] = (cyc == issued_at[p]) && h_w[p];
    end
    check_eq("req_ready", 32'(req_ready), 32'(er));
    check_eq("resp_valid", 32'(resp_valid), 32'(ev));
    check_eq("ram_mem_write", 32'(ram_mem_write), 32'(em));
    check_eq("stall_count", 32'(stall_count), 32'(stall));
    for (int p = 0; p < 2; p++)
      if (ev[p]) check_eq($sformatf("resp_rdata%0d", p), 32'(resp_rdata[p*12 +: 12]), 32'(exp_d[p]));
    @(posedge clk);
    if (rst_in) begin
      model_reset();
    end else begin
      acc = v & er;
      first = -1;
      nb = 0;
      for (int k = 0; k < 2; k++) begin
        int p;
        p = (rr + k) % 2;
        if (waiting[p]) begin
          blk = 0;
          foreach (granted[i])
            if (h_a[granted[i]] == h_a[p] && (h_w[p] || h_w[granted[i]])) blk = 1;
          if (blk) begin
            nb++;
            if (first < 0) first = p;
          end else granted.push_back(p);
        end
      end
      foreach (granted[i]) if (h_w[granted[i]]) begin
        ref_mem[h_a[granted[i]]] = h_d[granted[i]];
        exp_d[granted[i]] = h_d[granted[i]];
      end
      foreach (granted[i]) begin
        if (!h_w[granted[i]]) exp_d[granted[i]] = ref_mem[h_a[granted[i]]];
        waiting[granted[i]] = 0;
        issued_at[granted[i]] = cyc + 1;
      end
      if (first >= 0) rr = first;
      stall = (stall + nb > 65535) ? 65535 : stall + nb;
      for (int p = 0; p < 2; p++)
        if (acc[p]) begin
          waiting[p] = 1;
          h_w[p] = w[p];
          h_a[p] = p ? a1 : a0;
          h_d[p] = p ? d1 : d0;
        end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 2'b00, '0, '0, '0, '0);
  endtask

  initial begin
    reset = 1'b1;
    mem_clear = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr = '0;
    req_wdata = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    mem_clear = 1'b0;

    // Reset with both ports requesting
    step(1'b1, 2'b11, 2'b00, 12'h001, 12'h002, '0, '0);
    step(1'b1, 2'b11, 2'b00, 12'h001, 12'h002, '0, '0);
    // Port0 write then read of the same address
    step(1'b0, 2'b01, 2'b01, 12'h010, 12'h000, 12'hABC, '0);
    idle(3);
    step(1'b0, 2'b01, 2'b00, 12'h010, 12'h000, '0, '0);
    idle(4);
    // Same-address write/write collision, then read back
    step(1'b0, 2'b11, 2'b11, 12'h020, 12'h020, 12'h111, 12'h222);
    idle(5);
    step(1'b0, 2'b01, 2'b00, 12'h020, 12'h000, '0, '0);
    idle(4);
    // Read/read to the same address
    step(1'b0, 2'b11, 2'b00, 12'h030, 12'h030, '0, '0);
    idle(4);
    // Port0 keeps re-requesting while port1 contends for the same address
    step(1'b0, 2'b11, 2'b11, 12'h050, 12'h050, 12'h5A5, 12'h3C3);
    for (int i = 0; i < 12; i++)
      step(1'b0, 2'b01, 2'b01, 12'h050, 12'h050, 12'(i), 12'h000);
    idle(4);
    // Reset while port1 is ISSUED
    step(1'b0, 2'b10, 2'b10, 12'h000, 12'h060, '0, 12'h777);
    idle(1);
    step(1'b1, 2'b00, 2'b00, '0, '0, '0, '0);
    idle(3);
    step(1'b0, 2'b10, 2'b00, 12'h000, 12'h060, '0, '0);
    idle(4);

    // Randomized traffic on a small address set to provoke hazards
    for (int i = 0; i < 600; i++) begin
      logic [1:0] v, w;
      logic [11:0] a0, a1;
      v = 2'($urandom_range(0, 3));
      w = 2'($urandom_range(0, 3));
      a0 = 12'h100 + 12'($urandom_range(0, 3) * 16);
      a1 = 12'h100 + 12'($urandom_range(0, 3) * 16);
      step(($urandom_range(0, 79) == 0), v, w, a0, a1,
           12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
